// File: rtl/diego_pkg.sv
// Shared definitions for the tt_um_diego tile.
//   - UART receiver FSM state encoding
//   - UART framing constants (8N1, default oversampling ratio)
package diego_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 16;
    localparam int unsigned UART_DATA_BITS            = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/diego_sync2.sv
// Two-flop synchroniser for asynchronous input pins.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  synchronised output, two clk edges behind d
// RESET_VAL sets the value both flops take in reset, so a pin can come out
// of reset already at its idle level.
module diego_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/diego_uart_rx.sv
// UART 8N1 receive front end for tt_um_diego.
// Deserialises rx_i into bytes, holds one byte behind a valid/pop handshake
// and reports sticky framing and overrun errors.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   tile enable; low forces the receiver idle
//   rx_i         in   serial line (asynchronous, idle high)
//   rd_i         in   pop strobe for the held byte
//   clr_i        in   clears frame_err_o and overrun_o
//   data_o       out  held byte
//   valid_o      out  holding register contains an unread byte
//   frame_err_o  out  sticky: stop bit sampled low
//   overrun_o    out  sticky: completed byte dropped, holding register full
module diego_uart_rx
    import diego_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_i,
    input  logic       rd_i,
    input  logic       clr_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
    localparam int unsigned BitCntW = $clog2(UART_DATA_BITS);

    localparam logic [CntW-1:0]    CntHalfLast = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0]    CntFullLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitCntW-1:0] LastBit     = BitCntW'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 1023) begin : g_param_check
        $error("CLKS_PER_BIT must be in 4..1023");
    end

    // ------------------------------------------------------------------
    // Input synchroniser; resets to the idle line level.
    // ------------------------------------------------------------------
    logic rx_s;

    diego_sync2 #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_i),
        .q    (rx_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    uart_state_e                state_q, state_d;
    logic [CntW-1:0]            cnt_q;
    logic [BitCntW-1:0]         bit_cnt_q;
    logic [UART_DATA_BITS-1:0]  shift_q;
    // Cleared by a bad stop bit; a held break must go high before the
    // receiver will accept another start bit.
    logic                       armed_q;
    logic [UART_DATA_BITS-1:0]  data_q;
    logic                       valid_q;
    logic                       frame_err_q;
    logic                       overrun_q;

    logic hit_half;
    logic hit_full;

    assign hit_half = (cnt_q == CntHalfLast);
    assign hit_full = (cnt_q == CntFullLast);

    // FSM strobes
    logic cnt_clr;
    logic bit_clr;
    logic sample_data;
    logic stop_good;
    logic stop_bad;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (armed_q && !rx_s) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    // A start bit that is high again at mid-bit is a glitch.
                    if (hit_half) begin
                        state_d = rx_s ? StIdle : StData;
                    end
                end
                StData: begin
                    if (hit_full && (bit_cnt_q == LastBit)) begin
                        state_d = StStop;
                    end
                end
                StStop: begin
                    if (hit_full) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (counter control and sample strobes)
    // ------------------------------------------------------------------
    always_comb begin
        cnt_clr     = 1'b0;
        bit_clr     = 1'b0;
        sample_data = 1'b0;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
        if (!ena) begin
            cnt_clr = 1'b1;
            bit_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_clr = 1'b1;
                    bit_clr = 1'b1;
                end
                StStart: begin
                    cnt_clr = hit_half;
                end
                StData: begin
                    cnt_clr     = hit_full;
                    sample_data = hit_full;
                end
                StStop: begin
                    cnt_clr   = hit_full;
                    stop_good = hit_full & rx_s;
                    stop_bad  = hit_full & ~rx_s;
                end
                default: begin
                    cnt_clr = 1'b1;
                    bit_clr = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Baud counter, bit counter, shift register, re-arm flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b1;
        end else begin
            if (cnt_clr) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end

            if (bit_clr) begin
                bit_cnt_q <= '0;
            end else if (sample_data) begin
                bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end

            // LSB arrives first: shift in at the top, move right.
            if (sample_data) begin
                shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            end

            if (stop_bad) begin
                armed_q <= 1'b0;
            end else if (state_q == StIdle && rx_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register and sticky flags
    // ------------------------------------------------------------------
    logic pop;
    logic load;
    logic overrun_evt;

    assign pop         = rd_i & valid_q;
    // A same-cycle pop frees the slot for the incoming byte.
    assign load        = stop_good & (~valid_q | pop);
    assign overrun_evt = stop_good & valid_q & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (load) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
            // A new error event beats a same-cycle clear.
            frame_err_q <= stop_bad | (frame_err_q & ~clr_i);
            overrun_q   <= overrun_evt | (overrun_q & ~clr_i);
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_diego_uart_rx.sv
// Self-checking bench for diego_uart_rx (CLKS_PER_BIT = 16).
// The reference model works from the frame schedule: every fully sent frame
// posts an event at its stop-sample edge (t0 + 2 + H + 9*C), and the model
// applies push / pop / clear rules to an abstract holding register.
module tb_diego_uart_rx;

    localparam int C        = 16;
    localparam int H        = C / 2;
    localparam int STOP_OFS = 2 + H + 9 * C;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena   = 1'b1;
    logic       rx_i  = 1'b1;
    logic       rd_i  = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    always #5 clk = ~clk;

    diego_uart_rx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .rx_i       (rx_i),
        .rd_i       (rd_i),
        .clr_i      (clr_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    logic       chk_en     = 1'b0;
    int         valid_rise = -1;
    logic       prev_valid = 1'b0;

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_ovr   = 1'b0;

    int         ev_edge[$];
    logic       ev_good[$];
    logic [7:0] ev_byte[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Model: advance on every clock edge.
    initial begin
        logic       good;
        logic       bad;
        logic       pop;
        logic       ovr_evt;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
                ev_edge.delete(); ev_good.delete(); ev_byte.delete();
            end else begin
                good = 1'b0;
                bad  = 1'b0;
                b    = 8'h00;
                if (ev_edge.size() > 0 && ev_edge[0] == cyc) begin
                    good = ev_good[0];
                    bad  = ~ev_good[0];
                    b    = ev_byte[0];
                    void'(ev_edge.pop_front());
                    void'(ev_good.pop_front());
                    void'(ev_byte.pop_front());
                end
                pop     = rd_i && m_valid;
                ovr_evt = good && m_valid && !pop;
                if (good && (!m_valid || pop)) begin
                    m_data  = b;
                    m_valid = 1'b1;
                end else if (pop) begin
                    m_valid = 1'b0;
                end
                m_fe  = bad ? 1'b1 : (clr_i ? 1'b0 : m_fe);
                m_ovr = ovr_evt ? 1'b1 : (clr_i ? 1'b0 : m_ovr);
            end
        end
    end

    // Asynchronous reset of the model.
    initial begin
        forever begin
            @(negedge rst_n);
            m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
            ev_edge.delete(); ev_good.delete(); ev_byte.delete();
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("data_o",      32'(data_o),      32'(m_data));
                check("valid_o",     32'(valid_o),     32'(m_valid));
                check("frame_err_o", 32'(frame_err_o), 32'(m_fe));
                check("overrun_o",   32'(overrun_o),   32'(m_ovr));
                if (valid_o === 1'b1 && prev_valid !== 1'b1 && valid_rise < 0) begin
                    valid_rise = cyc;
                end
                prev_valid = valid_o;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_at_stop,
                              output int t0);
        logic [9:0] bits;
        int         stop_edge;
        bits      = {stop, b, 1'b0};
        t0        = 0;
        stop_edge = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) begin
                    t0        = cyc + 1;
                    stop_edge = t0 + STOP_OFS;
                    ev_edge.push_back(stop_edge);
                    ev_good.push_back(stop);
                    ev_byte.push_back(b);
                end
                rx_i = bits[i];
                if (rd_at_stop) rd_i = (cyc + 1 == stop_edge);
            end
        end
        if (rd_at_stop) rd_i = 1'b0;
    endtask

    // Start bit plus nfull data bits, then extra cycles of the next bit.
    task automatic send_partial(input logic [7:0] b, input int nfull, input int extra);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int n = 0; n < C * (1 + nfull) + extra; n++) begin
            @(negedge clk);
            rx_i = bits[n / C];
        end
    endtask

    task automatic pulse_rd();
        @(negedge clk); rd_i = 1'b1;
        @(negedge clk); rd_i = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_i = 1'b1;
        @(negedge clk); clr_i = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic v,
                              input logic fe, input logic ov);
        check({tag, " data"},  32'(data_o),      32'(d));
        check({tag, " valid"}, 32'(valid_o),     32'(v));
        check({tag, " ferr"},  32'(frame_err_o), 32'(fe));
        check({tag, " ovr"},   32'(overrun_o),   32'(ov));
    endtask

    initial begin
        int t0;
        #1 rst_n = 1'b0;
        idle(3);
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        idle(5);

        // Single good frame, exact valid timing, then pop.
        valid_rise = -1;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        idle(4);
        check_outs("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5 valid_rise_ofs", 32'(valid_rise - t0), 32'd154);
        pulse_rd();
        check("a5 pop valid", 32'(valid_o), 32'd0);
        check("a5 pop data", 32'(data_o), 32'hA5);

        // 4-cycle low glitch on idle line.
        @(negedge clk) rx_i = 1'b0;
        idle(3);
        @(negedge clk) rx_i = 1'b1;
        idle(40);
        check_outs("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Bad stop bit followed by a held break; a mid-break clear must stick.
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        idle(2);
        check_outs("brk", 8'hA5, 1'b0, 1'b1, 1'b0);
        idle(5 * C);
        pulse_clr();
        idle(34 * C);
        check("brk single ferr", 32'(frame_err_o), 32'd0);
        @(negedge clk) rx_i = 1'b1;
        idle(2 * C);
        pulse_clr();
        check("brk clr ferr", 32'(frame_err_o), 32'd0);

        // Overrun without pop.
        send_frame(8'h11, 1'b1, 1'b0, t0);
        send_frame(8'h22, 1'b1, 1'b0, t0);
        idle(4);
        check_outs("ovr", 8'h11, 1'b1, 1'b0, 1'b1);
        pulse_clr();
        pulse_rd();
        idle(2);
        check_outs("ovr clr", 8'h11, 1'b0, 1'b0, 1'b0);

        // Same-cycle pop and push.
        send_frame(8'h11, 1'b1, 1'b0, t0);
        send_frame(8'h22, 1'b1, 1'b1, t0);
        idle(4);
        check_outs("popush", 8'h22, 1'b1, 1'b0, 1'b0);

        // Reset during data bit 4 with a byte still held.
        send_partial(8'h55, 4, 8);
        #3 rst_n = 1'b0;
        #1 check_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rx_i = 1'b1;
        idle(3);
        @(negedge clk) rst_n = 1'b1;
        idle(5);
        send_frame(8'h7E, 1'b1, 1'b0, t0);
        idle(4);
        check_outs("7e", 8'h7E, 1'b1, 1'b0, 1'b0);
        pulse_rd();

        // Enable dropped during data bit 2.
        send_partial(8'h66, 2, 8);
        @(negedge clk);
        ena  = 1'b0;
        rx_i = 1'b1;
        idle(3 * C);
        @(negedge clk) ena = 1'b1;
        idle(C);
        check_outs("ena", 8'h7E, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, t0);
        idle(4);
        check_outs("81", 8'h81, 1'b1, 1'b0, 1'b0);

        idle(4);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/diego_uart_rx.md
# diego_uart_rx

- UART receive front end for `tt_um_diego`, 8N1 format.
- Sits directly upstream of the design core: it deserialises the bit stream arriving on `ui_in[0]` into bytes.
- Each byte is presented through a one-entry holding register with a valid/pop handshake.
- Framing and overrun errors are flagged as sticky bits the top maps onto `uo_out`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range 4..1023; the counter width is derived from it.

Ports:
- `clk`  in  1  system clock. The block has one clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `ena`  in  1  tile enable. Low forces the receiver idle.
- `rx_i`  in  1  serial line, asynchronous to `clk`. Idle level is 1.
- `rd_i`  in  1  pop strobe. Consumes the held byte when `valid_o` = 1.
- `clr_i`  in  1  clears `frame_err_o` and `overrun_o`.
- `data_o`  out  8  received byte, LSB-first reassembled.
- `valid_o`  out  1  the holding register contains an unread byte.
- `frame_err_o`  out  1  sticky: a stop bit was sampled as 0.
- `overrun_o`  out  1  sticky: a completed byte was dropped because the holding register was full.

## Operation
- Synchroniser: `rx_i` passes through a 2-flop synchroniser whose flops reset to 1. The synchronised value is `rx_s`.
- FSM states and transitions:
  - IDLE: stays while `rx_s` = 1. `rx_s` = 0 → START, bit counter cleared.
  - START: wait `CLKS_PER_BIT/2` cycles (floor), then sample `rx_s`.
    - Sample = 1 → IDLE. This is a glitch; nothing is flagged.
    - Sample = 0 → DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. Shift the sample into bit 7 of the shift register and shift right, so the first bit lands at bit 0. After 8 samples → STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles, then → IDLE.
    - Sample 1: push the byte.
    - Sample 0: set `frame_err_o` and discard the byte.
    - After a stop-bit 0, IDLE re-arms only once `rx_s` has been seen at 1 for at least one cycle. A held break therefore produces exactly one frame error.
- Push into the holding register:
  - Register empty: load the byte, `valid_o` ← 1.
  - Register full, no pop in the same cycle: drop the new byte, set `overrun_o`, `data_o` unchanged.
  - Register full with a same-cycle pop: load the new byte, `valid_o` stays 1, no overrun.
- Pop: `rd_i` with `valid_o` = 1 clears `valid_o` next cycle. `rd_i` with `valid_o` = 0 is ignored.
- Clear: `clr_i` clears both sticky flags. An error event in the same cycle wins, so the flag stays set.
- `ena` low:
  - FSM is forced to IDLE and any partial frame is discarded.
  - Holding register and flags are retained.
  - `rd_i` and `clr_i` still act.
- Reset (asynchronous, any time, including mid-frame):
  - FSM → IDLE; counters and shift register → 0; synchroniser → 1.
  - `data_o` = 0x00, `valid_o` = 0, `frame_err_o` = 0, `overrun_o` = 0.

## Timing
- Let edge t0 be the first `clk` edge at which `rx_i` = 0 is captured by synchroniser stage 1.
- `rx_s` = 0 is visible to the FSM at edge k = t0+2.
- Sample points, with H = floor(`CLKS_PER_BIT`/2):
  - start bit: edge k+H
  - data bit i (i = 0..7): edge k+H+(i+1)·`CLKS_PER_BIT`
  - stop bit: edge k+H+9·`CLKS_PER_BIT`
- `valid_o`, `frame_err_o` and `overrun_o` change on the stop-sample edge, so they are visible the cycle after it.
- Back-to-back frames are accepted: a new start bit may begin immediately after the stop sample.
- Pop: `valid_o` falls on the edge that samples `rd_i` = 1. `data_o` holds its value until the next push.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `diego_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP)
  - `UART_CLKS_PER_BIT_DEFAULT` = 16
  - `UART_DATA_BITS` = 8
- One sub-module, `diego_sync2`: a 2-flop synchroniser with a parameterised reset value. It is reused by other asynchronous pins of the top.
- Everything else lives in `diego_uart_rx`: FSM, baud counter, bit counter, shift register, holding register and flags.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- Single frame 0xA5 with a good stop bit → `data_o` = 0xA5, `valid_o` rises exactly at stop-sample edge + 1, both flags 0; `rd_i` pulse → `valid_o` = 0 next cycle.
- 4-cycle low glitch on an idle line → FSM returns to IDLE; `valid_o`, `frame_err_o` and `overrun_o` all stay 0.
- Frame 0x3C with stop bit 0, then line held low for 40 bit times → `frame_err_o` = 1 exactly once, `valid_o` = 0; `clr_i` → `frame_err_o` = 0.
- Frames 0x11 then 0x22 with no pop → `data_o` = 0x11, `overrun_o` = 1. Repeat with `rd_i` asserted on the second stop-sample edge → `data_o` = 0x22, `valid_o` = 1, `overrun_o` = 0.
- `rst_n` asserted during data bit 4 → all outputs 0 immediately. A full frame 0x7E after release is received correctly.
- `ena` dropped during data bit 2, then raised → partial frame discarded with no flags. The next frame 0x81 is received correctly.
